// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate backed by a word-organised SRAM array.
// The SRAM is the memory-side endpoint for data cache line fills, write-backs
// and write-through stores. Each data phase is stretched by a programmable
// number of wait states (separate counts for NONSEQ and SEQ beats). Illegal
// accesses get the two-cycle ERROR response. Read data is registered on the
// edge that enters the DATA cycle. A same-word write in the preceding DATA
// cycle is forwarded into that read.
module ahb_sram_slave #(
    parameter int MEM_BYTES = 4096,
    parameter int NSEQ_WAIT = 1,
    parameter int SEQ_WAIT  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HMASTLOCK,
    input  logic [3:0]  HPROT,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int IW    = AW - 2;
    localparam int WORDS = MEM_BYTES / 4;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    lane_q, lane_d;
    logic [1:0]    size_q, size_d;
    logic          write_q, write_d;
    logic [31:0]   hrdata_q, hrdata_d;

    logic [31:0]   mem [WORDS];

    logic          accept;
    logic          illegal;
    logic [2:0]    wait_cnt;
    logic [3:0]    be;
    logic          do_write;
    logic [31:0]   wr_word;
    logic [IW-1:0] rd_idx;
    logic          rd_write;
    logic          bypass_hit;

    // Burst type, lock and protection do not affect this memory.
    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT};

    // A new address phase can only land while our own data phase is not stalling.
    assign accept = HSEL && HTRANS[1] && HREADY &&
                    (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2);

    assign illegal = (HADDR >= 32'(MEM_BYTES)) || (HSIZE > 3'd2) ||
                     (HSIZE == 3'd1 && HADDR[0]) ||
                     (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);

    assign wait_cnt = HTRANS[0] ? 3'(SEQ_WAIT) : 3'(NSEQ_WAIT);

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  en);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = en[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

    // Next-state and handshake outputs; a pipelined capture overrides the state's own exit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        size_d    = size_q;
        write_d   = write_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state_q)
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q <= 3'd1) state_d = S_DATA;
                else               cnt_d   = cnt_q - 3'd1;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                HRESP   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            idx_d   = HADDR[AW-1:2];
            lane_d  = HADDR[1:0];
            size_d  = HSIZE[1:0];
            write_d = HWRITE;
            if (illegal) begin
                state_d = S_ERR1;
            end else if (wait_cnt == 3'd0) begin
                state_d = S_DATA;
            end else begin
                state_d = S_WAIT;
                cnt_d   = wait_cnt;
            end
        end
    end

    // Byte enables of the access currently in its data phase.
    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be[lane_q] = 1'b1;
            2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign do_write = (state_q == S_DATA) && write_q;
    assign wr_word  = merge_lanes(mem[idx_q], HWDATA, be);

    // A read entering DATA comes from the fresh capture or from the waited transfer.
    assign rd_idx     = accept ? HADDR[AW-1:2] : idx_q;
    assign rd_write   = accept ? HWRITE : write_q;
    assign bypass_hit = do_write && (idx_q == rd_idx);

    // Load read data on the edge into DATA; forward a same-word write still in flight.
    always_comb begin
        hrdata_d = hrdata_q;
        if (state_d == S_DATA && !rd_write) begin
            hrdata_d = bypass_hit ? wr_word : mem[rd_idx];
        end
    end

    // Control and pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            lane_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            hrdata_q <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            size_q   <= size_d;
            write_q  <= write_d;
            hrdata_q <= hrdata_d;
        end
    end

    // SRAM word update at the end of a write DATA cycle.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents survive reset and it maps onto SRAM macros.
        if (do_write) mem[idx_q] <= wr_word;
    end

    assign HRDATA = hrdata_q;

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder (subordinate) backed by a synchronous word-organised SRAM array.
- Serves as the memory-side endpoint for the data cache's line fills, write-backs and write-through stores.
- Supports SINGLE, INCR4 and WRAP4 bursts, byte/halfword/word sizes, and programmable wait states.
- Returns a two-cycle ERROR response for illegal accesses.

Parameters:
- MEM_BYTES, 4096, SRAM capacity in bytes; power of two; valid address range 0..MEM_BYTES-1.
- NSEQ_WAIT, 1, wait states inserted on a NONSEQ data phase (0..7).
- SEQ_WAIT, 0, wait states inserted on a SEQ data phase (0..7).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HBURST  in  3  burst type (ignored for decode; addresses come from the master)
- HMASTLOCK  in  1  ignored
- HPROT  in  4  ignored
- HSIZE  in  3  0=byte, 1=half, 2=word
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWDATA  in  32  write data (data phase)
- HWRITE  in  1  1=write
- HREADY  in  1  bus-level ready; qualifies the address phase
- HREADYOUT  out  1  slave ready
- HRDATA  out  32  read data
- HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE. All pipeline registers are cleared. SRAM contents are not cleared.
- Address-phase capture:
  - Capture occurs when HSEL && HTRANS[1] && HREADY.
  - Registered: addr, size, write, seq flag (HTRANS==11).
  - Otherwise no transfer is pending. IDLE, BUSY and unselected cycles get a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Error check at capture:
  - addr >= MEM_BYTES, HSIZE>2, or misaligned (half with addr[0]=1; word with addr[1:0]!=0) → ERROR path.
- States:
  - IDLE: default.
  - WAIT: counter counts down from NSEQ_WAIT or SEQ_WAIT; HREADYOUT=0.
  - DATA: HREADYOUT=1, OKAY; the access completes this cycle.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - Legal capture with wait count 0 → DATA.
  - Legal capture with wait count >0 → WAIT; WAIT → DATA when the counter reaches 1.
  - Illegal capture → ERR1 → ERR2.
  - From DATA or ERR2, a new capture in the same cycle (pipelined address phase) goes straight to its next state. With no new capture → IDLE.
- Data-phase latency: total data-phase length = wait count + 1 cycles.
  - Back-to-back zero-wait transfers sustain 1 beat per clock.
- Writes:
  - HWDATA is sampled in the DATA cycle.
  - Byte lanes come from size and addr[1:0]: byte → lane addr[1:0]; half → lanes {addr[1],0}+1 and {addr[1],0}; word → all lanes.
  - The SRAM word is updated at the end of the DATA cycle.
- Reads:
  - HRDATA is valid in the DATA cycle: the full 32-bit word at addr[log2(MEM_BYTES)-1:2], lanes unshifted.
  - HRDATA holds its value outside DATA.
- Read-after-write hazard: a read whose DATA cycle immediately follows a write DATA cycle to the same word must return the merged, newly written data (bypass path required).
- ERROR path: no SRAM update, no HRDATA update. The master may drop the burst; the next NONSEQ is accepted in the ERR2 cycle.
- BUSY inside a burst: treated as IDLE (zero-wait OKAY, no access). The following SEQ uses SEQ_WAIT.
- HSEL deasserted mid-WAIT: the pending transfer still completes (data phase already owned).
- Reset mid-operation: immediate return to IDLE, HREADYOUT=1. A partially waited write is not committed.

Test Plan:
- Single word write 0xDEADBEEF @0x10, then read @0x10, NSEQ_WAIT=1 → each data phase shows 1 cycle HREADYOUT=0 then 1; read returns 0xDEADBEEF, HRESP=0.
- INCR4 write 0x11,0x22,0x33,0x44 @0x20, then WRAP4 read starting @0x28 (0x28,0x2C,0x20,0x24) with SEQ_WAIT=0 → read beats 0x33,0x44,0x11,0x22; SEQ beats zero-wait.
- Byte write 0xAB @0x41 over word 0x00000000, then halfword write 0x1234 @0x42 → word @0x40 reads 0x1234AB00.
- Read @MEM_BYTES (0x1000), then misaligned word @0x02 → each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
- NSEQ_WAIT=0: write 0x5A5A5A5A @0x80 immediately followed by read @0x80 → read returns 0x5A5A5A5A via bypass; 1 beat per clock.
- Assert reset during the WAIT of a write 0xFFFFFFFF @0x90 (NSEQ_WAIT=3) → HREADYOUT=1, HRESP=0 next edge; a later read @0x90 returns the old value.
